// File: rtl/dbus_uncached_axi_bridge.sv
// Uncached CPU data-bus to single-beat AXI3 bridge: one bus request becomes one AXI read or write.
// Latency: 4 cycles minimum for a read (IDLE, RD_ADDR, RD_DATA, DONE) with zero-wait slaves.
// Backpressure: dbus_stall holds the CPU until DONE for its own request; AXI ready/valid stalls the FSM.
//
// Ports: clk/rst_n (async active-low); dbus_read/dbus_write/dbus_byte_en/dbus_address/dbus_wdata
// request in; dbus_stall/dbus_rdata back to the CPU; axi_req/axi_resp are the AXI3 master structs.

package dbus_axi_pkg;

    typedef struct packed {
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [3:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic [1:0]  arlock;
        logic [3:0]  arcache;
        logic [2:0]  arprot;
        logic        arvalid;
        logic        rready;
        logic [3:0]  awid;
        logic [31:0] awaddr;
        logic [3:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic [1:0]  awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic        awvalid;
        logic [3:0]  wid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
    } axi_req_t;

    typedef struct packed {
        logic        arready;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
        logic        awready;
        logic        wready;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        logic        bvalid;
    } axi_resp_t;

endpackage

module dbus_uncached_axi_bridge
    import dbus_axi_pkg::*;
#(
    parameter logic [31:0] PADDR_MASK = 32'h1FFF_FFFF,
    parameter bit          WAIT_RESP  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [3:0]  dbus_byte_en,
    input  logic [31:0] dbus_address,
    input  logic [31:0] dbus_wdata,
    output logic        dbus_stall,
    output logic [31:0] dbus_rdata,
    output axi_req_t    axi_req,
    input  axi_resp_t   axi_resp
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP,
        DONE
    } state_t;

    state_t      state;
    logic        cap_write;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic [31:0] rdata_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;

    logic        req;
    logic        req_match;
    logic        aw_left;
    logic        w_left;

    // Response metadata is deliberately ignored: one outstanding beat, no error reporting to the CPU.
    logic unused_resp;
    assign unused_resp = ^{axi_resp.rid, axi_resp.rresp, axi_resp.rlast, axi_resp.bid, axi_resp.bresp};

    function automatic logic [2:0] size_of(input logic [3:0] be);
        case (be)
            4'b0011, 4'b1100:                   return 3'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 3'd0;
            default:                            return 3'd2;
        endcase
    endfunction

    assign req = dbus_read | dbus_write;

    // The CPU's current request is the one in flight only if type, physical address and lanes agree;
    // otherwise the finished transaction belongs to a flushed or replaced request and is dropped.
    assign req_match = (dbus_write == cap_write)
                    && ((dbus_address & PADDR_MASK) == cap_addr)
                    && (dbus_byte_en == cap_be);

    assign dbus_stall = req & ~((state == DONE) & req_match);
    assign dbus_rdata = rdata_q;

    // A channel is still owed a handshake if its valid is up and ready did not arrive this cycle.
    assign aw_left = awvalid_q & ~axi_resp.awready;
    assign w_left  = wvalid_q & ~axi_resp.wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_be    <= '0;
            cap_wdata <= '0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_write <= dbus_write;
                        cap_addr  <= dbus_address & PADDR_MASK;
                        cap_be    <= dbus_byte_en;
                        cap_wdata <= dbus_wdata;
                        // Write wins when both strobes are up.
                        if (dbus_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (axi_resp.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi_resp.rvalid) begin
                        rdata_q  <= axi_resp.rdata;
                        rready_q <= 1'b0;
                        state    <= DONE;
                    end
                end
                WR: begin
                    awvalid_q <= aw_left;
                    wvalid_q  <= w_left;
                    if (!aw_left && !w_left) begin
                        if (WAIT_RESP) begin
                            bready_q <= 1'b1;
                            state    <= WR_RESP;
                        end else begin
                            state    <= DONE;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_resp.bvalid) begin
                        bready_q <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        axi_req         = '0;
        axi_req.araddr  = cap_addr;
        axi_req.arsize  = size_of(cap_be);
        axi_req.arburst = 2'b01;
        axi_req.arvalid = arvalid_q;
        axi_req.rready  = rready_q;
        axi_req.awaddr  = cap_addr;
        axi_req.awsize  = size_of(cap_be);
        axi_req.awburst = 2'b01;
        axi_req.awvalid = awvalid_q;
        axi_req.wdata   = cap_wdata;
        axi_req.wstrb   = cap_be;
        axi_req.wlast   = 1'b1;
        axi_req.wvalid  = wvalid_q;
        axi_req.bready  = bready_q;
    end

endmodule

// File: tb/tb_dbus_uncached_axi_bridge.sv
module tb_dbus_uncached_axi_bridge;
    import dbus_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dbus_read = 1'b0;
    logic        dbus_write = 1'b0;
    logic [3:0]  dbus_byte_en = 4'h0;
    logic [31:0] dbus_address = 32'h0;
    logic [31:0] dbus_wdata = 32'h0;
    logic        dbus_stall;
    logic [31:0] dbus_rdata;
    axi_req_t    axi_req;
    axi_resp_t   axi_resp;

    dbus_uncached_axi_bridge #(
        .PADDR_MASK (32'h1FFF_FFFF),
        .WAIT_RESP  (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dbus_read    (dbus_read),
        .dbus_write   (dbus_write),
        .dbus_byte_en (dbus_byte_en),
        .dbus_address (dbus_address),
        .dbus_wdata   (dbus_wdata),
        .dbus_stall   (dbus_stall),
        .dbus_rdata   (dbus_rdata),
        .axi_req      (axi_req),
        .axi_resp     (axi_resp)
    );

    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    int          ar_lat = 0;
    int          aw_lat = 0;
    int          w_lat = 0;
    logic        r_hold = 1'b0;
    logic        rd_use_addr = 1'b0;
    logic [31:0] rd_word = 32'h0;

    int          ar_cnt = 0;
    int          aw_cnt = 0;
    int          w_cnt = 0;
    logic        r_pend = 1'b0;
    logic [31:0] r_q = 32'h0;
    logic        b_pend = 1'b0;
    logic        aw_got = 1'b0;
    logic        w_got = 1'b0;

    always_comb begin
        axi_resp         = '0;
        axi_resp.arready = axi_req.arvalid && (ar_cnt >= ar_lat);
        axi_resp.rvalid  = r_pend && !r_hold;
        axi_resp.rdata   = r_q;
        axi_resp.rlast   = 1'b1;
        axi_resp.awready = axi_req.awvalid && (aw_cnt >= aw_lat);
        axi_resp.wready  = axi_req.wvalid && (w_cnt >= w_lat);
        axi_resp.bvalid  = b_pend;
    end

    wire aw_hs_w = axi_req.awvalid && axi_resp.awready;
    wire w_hs_w  = axi_req.wvalid && axi_resp.wready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
            r_pend <= 1'b0; r_q <= 32'h0;
            b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            ar_cnt <= (axi_req.arvalid && !axi_resp.arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (axi_req.awvalid && !axi_resp.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi_req.wvalid && !axi_resp.wready) ? w_cnt + 1 : 0;
            if (axi_req.arvalid && axi_resp.arready) begin
                r_pend <= 1'b1;
                r_q    <= rd_use_addr ? (32'hC0DE_0000 | axi_req.araddr) : rd_word;
            end else if (axi_resp.rvalid && axi_req.rready) begin
                r_pend <= 1'b0;
            end
            if (b_pend && axi_req.bready) b_pend <= 1'b0;
            if ((aw_hs_w || aw_got) && (w_hs_w || w_got) && (aw_hs_w || w_hs_w)) begin
                b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_hs_w) aw_got <= 1'b1;
                if (w_hs_w)  w_got  <= 1'b1;
            end
        end
    end

    // ---------------- bus monitors ----------------
    int          ar_cyc = 0;
    int          ar_hs = 0;
    int          r_hs = 0;
    int          aw_hs = 0;
    int          w_hs = 0;
    logic [31:0] last_araddr = 32'h0;
    logic [2:0]  last_arsize = 3'h0;
    logic [3:0]  last_arlen = 4'h0;
    logic [2:0]  last_awsize = 3'h0;
    logic [31:0] last_wdata = 32'h0;
    logic [3:0]  last_wstrb = 4'h0;

    always @(posedge clk) begin
        if (axi_req.arvalid) ar_cyc <= ar_cyc + 1;
        if (axi_req.arvalid && axi_resp.arready) begin
            ar_hs <= ar_hs + 1;
            last_araddr <= axi_req.araddr;
            last_arsize <= axi_req.arsize;
            last_arlen  <= axi_req.arlen;
        end
        if (axi_req.rready && axi_resp.rvalid) r_hs <= r_hs + 1;
        if (aw_hs_w) begin
            aw_hs <= aw_hs + 1;
            last_awsize <= axi_req.awsize;
        end
        if (w_hs_w) begin
            w_hs <= w_hs + 1;
            last_wdata <= axi_req.wdata;
            last_wstrb <= axi_req.wstrb;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Issue a request at a negedge and hold it until stall drops (bounded); returns stall-high cycles.
    task automatic do_req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          output int hi, output logic [31:0] rdv);
        dbus_read = rd; dbus_write = wr; dbus_address = a; dbus_byte_en = be; dbus_wdata = wd;
        hi = 0;
        #1;
        while (dbus_stall && hi < 50) begin
            hi++;
            @(negedge clk); #1;
        end
        check(tag, 32'(dbus_stall), 32'd0);
        rdv = dbus_rdata;
        @(negedge clk);
        dbus_read = 1'b0; dbus_write = 1'b0;
    endtask

    int          hi;
    logic [31:0] rdv;
    int          s_ar, s_arh, s_rh, s_aw, s_w;
    logic        stall_any;

    initial begin
        // ---- reset state ----
        @(negedge clk); #1;
        check("rst_stall_idle", 32'(dbus_stall), 32'd0);
        check("rst_arvalid", 32'(axi_req.arvalid), 32'd0);
        check("rst_awvalid", 32'(axi_req.awvalid), 32'd0);
        check("rst_wvalid", 32'(axi_req.wvalid), 32'd0);
        check("rst_rready", 32'(axi_req.rready), 32'd0);
        check("rst_bready", 32'(axi_req.bready), 32'd0);
        check("rst_rdata", dbus_rdata, 32'h0);
        dbus_read = 1'b1; #1;
        check("rst_stall_req", 32'(dbus_stall), 32'd1);
        dbus_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- zero-wait read ----
        rd_word = 32'hDEAD_BEEF;
        do_req("rd_done", 1'b1, 1'b0, 32'hBFD0_0010, 4'b1111, 32'h0, hi, rdv);
        check("rd_stall_cycles", 32'(hi), 32'd3);
        check("rd_rdata", rdv, 32'hDEAD_BEEF);
        check("rd_araddr", last_araddr, 32'h1FD0_0010);
        check("rd_arsize", 32'(last_arsize), 32'd2);
        check("rd_arlen", 32'(last_arlen), 32'd0);

        // ---- write with AW/W skew ----
        aw_lat = 1; w_lat = 3;
        dbus_write = 1'b1; dbus_address = 32'hA000_0004; dbus_byte_en = 4'b1100;
        dbus_wdata = 32'h1234_5678; #1;
        check("wr_c0_stall", 32'(dbus_stall), 32'd1);
        @(negedge clk); #1;
        check("wr_c1_awvalid", 32'(axi_req.awvalid), 32'd1);
        check("wr_c1_wvalid", 32'(axi_req.wvalid), 32'd1);
        check("wr_awsize", 32'(axi_req.awsize), 32'd1);
        check("wr_wstrb", 32'(axi_req.wstrb), 32'hC);
        check("wr_awaddr", axi_req.awaddr, 32'h0000_0004);
        check("wr_awburst", 32'(axi_req.awburst), 32'd1);
        check("wr_wlast", 32'(axi_req.wlast), 32'd1);
        @(negedge clk); #1;
        check("wr_c2_awvalid", 32'(axi_req.awvalid), 32'd1);
        @(negedge clk); #1;
        check("wr_c3_awvalid_drop", 32'(axi_req.awvalid), 32'd0);
        check("wr_c3_wvalid_held", 32'(axi_req.wvalid), 32'd1);
        @(negedge clk); #1;
        check("wr_c4_wvalid_held", 32'(axi_req.wvalid), 32'd1);
        check("wr_c4_stall", 32'(dbus_stall), 32'd1);
        @(negedge clk); #1;
        check("wr_c5_wvalid_drop", 32'(axi_req.wvalid), 32'd0);
        check("wr_c5_bready", 32'(axi_req.bready), 32'd1);
        check("wr_c5_stall", 32'(dbus_stall), 32'd1);
        @(negedge clk); #1;
        check("wr_c6_stall_low", 32'(dbus_stall), 32'd0);
        check("wr_wdata", last_wdata, 32'h1234_5678);
        @(negedge clk);
        dbus_write = 1'b0;

        // ---- read and write together: write wins ----
        aw_lat = 0; w_lat = 0;
        s_ar = ar_cyc; s_aw = aw_hs; s_w = w_hs;
        do_req("both_done", 1'b1, 1'b1, 32'h8000_0100, 4'b1111, 32'hCAFE_F00D, hi, rdv);
        check("both_stall_cycles", 32'(hi), 32'd3);
        check("both_no_arvalid", 32'(ar_cyc - s_ar), 32'd0);
        check("both_aw_hs", 32'(aw_hs - s_aw), 32'd1);
        check("both_w_hs", 32'(w_hs - s_w), 32'd1);
        check("both_wdata", last_wdata, 32'hCAFE_F00D);
        check("both_wstrb", 32'(last_wstrb), 32'hF);
        check("both_awsize", 32'(last_awsize), 32'd2);

        // ---- withdrawn read (flush) ----
        ar_lat = 5;
        s_ar = ar_cyc; s_arh = ar_hs; s_rh = r_hs; stall_any = 1'b0;
        dbus_read = 1'b1; dbus_address = 32'hA000_0020; dbus_byte_en = 4'b1111; #1;
        @(negedge clk); #1;
        check("fl_arvalid", 32'(axi_req.arvalid), 32'd1);
        dbus_read = 1'b0; #1;
        for (int i = 0; i < 12; i++) begin
            stall_any = stall_any | dbus_stall;
            @(negedge clk); #1;
        end
        check("fl_stall_low", 32'(stall_any), 32'd0);
        check("fl_arvalid_cycles", 32'(ar_cyc - s_ar), 32'd6);
        check("fl_ar_hs", 32'(ar_hs - s_arh), 32'd1);
        check("fl_r_hs", 32'(r_hs - s_rh), 32'd1);
        check("fl_idle_arvalid", 32'(axi_req.arvalid), 32'd0);
        check("fl_idle_rready", 32'(axi_req.rready), 32'd0);

        // ---- swapped read ----
        ar_lat = 2; rd_use_addr = 1'b1;
        s_arh = ar_hs;
        dbus_read = 1'b1; dbus_address = 32'hA000_0000; dbus_byte_en = 4'b1111; #1;
        hi = 1;
        @(negedge clk); #1;
        check("sw_araddr_first", axi_req.araddr, 32'h0000_0000);
        dbus_address = 32'hA000_0008; #1;
        while (dbus_stall && hi < 50) begin
            hi++;
            @(negedge clk); #1;
        end
        check("sw_stall_cycles", 32'(hi), 32'd11);
        check("sw_rdata", dbus_rdata, 32'hC0DE_0008);
        check("sw_ar_hs", 32'(ar_hs - s_arh), 32'd2);
        check("sw_araddr_second", last_araddr, 32'h0000_0008);
        @(negedge clk);
        dbus_read = 1'b0;

        // ---- asynchronous reset during RD_DATA ----
        ar_lat = 0; r_hold = 1'b1;
        dbus_read = 1'b1; dbus_address = 32'h8000_0020; dbus_byte_en = 4'b1111; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("ar_rd_data_rready", 32'(axi_req.rready), 32'd1);
        check("ar_rdata_before", dbus_rdata, 32'hC0DE_0008);
        #1 rst_n = 1'b0;
        #1;
        check("ar_arvalid", 32'(axi_req.arvalid), 32'd0);
        check("ar_rready", 32'(axi_req.rready), 32'd0);
        check("ar_rdata", dbus_rdata, 32'h0);
        check("ar_stall_req", 32'(dbus_stall), 32'd1);
        dbus_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; r_hold = 1'b0; rd_use_addr = 1'b0;

        // ---- recovery and size encodings ----
        rd_word = 32'h0000_00A5;
        do_req("sz1_done", 1'b1, 1'b0, 32'h8000_0040, 4'b0001, 32'h0, hi, rdv);
        check("sz1_stall_cycles", 32'(hi), 32'd3);
        check("sz1_rdata", rdv, 32'h0000_00A5);
        check("sz1_arsize", 32'(last_arsize), 32'd0);
        check("sz1_araddr", last_araddr, 32'h0000_0040);
        rd_word = 32'h0BAD_CAFE;
        do_req("sz2_done", 1'b1, 1'b0, 32'h0000_0044, 4'b0110, 32'h0, hi, rdv);
        check("sz2_arsize", 32'(last_arsize), 32'd2);
        check("sz2_rdata", rdv, 32'h0BAD_CAFE);
        do_req("sz3_done", 1'b1, 1'b0, 32'h0000_0048, 4'b0011, 32'h0, hi, rdv);
        check("sz3_arsize", 32'(last_arsize), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dbus_uncached_axi_bridge.md
Name: dbus_uncached_axi_bridge

Overview:
- Downstream consumer of the CPU data-bus master (cpu_dbus_if slave side) for uncached accesses.
- Turns each single read or write request into one single-beat AXI3 transaction on an axi_req_t / axi_resp_t pair.
- Holds the CPU with stall until the transaction completes.
- Sits between the MEM-stage dbus mux and the top-level AXI crossbar.

Parameters:
- PADDR_MASK, 32'h1FFF_FFFF, ANDed with address to form araddr/awaddr (strips kseg bits).
- WAIT_RESP, 1, 1: a write completes on bvalid; 0: a write completes when both the AW and W handshakes are done.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- dbus_read  input  1  read request, held until stall is low
- dbus_write  input  1  write request, held until stall is low
- dbus_byte_en  input  4  byte enables; bit i covers wdata[8i+7:8i]
- dbus_address  input  32  virtual/physical byte address
- dbus_wdata  input  32  write data
- dbus_stall  output  1  CPU must hold its request while high
- dbus_rdata  output  32  read data, valid while the DONE state is presented
- axi_req  output  $bits(axi_req_t)  AXI master request struct
- axi_resp  input  $bits(axi_resp_t)  AXI slave response struct

Behaviour:
- Reset: asynchronous, active-low (rst_n=0), one clock (clk). Output and register values while reset is asserted:
  - state=IDLE; all valid bits 0; rready=0, bready=0; dbus_rdata=0; captured request cleared.
  - dbus_stall = dbus_read|dbus_write.
- Reset mid-transaction aborts with no AXI completion; the AXI side is reset with the core.
- Request: req = dbus_read|dbus_write. If both are set, the write wins.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR (AW+W), WR_RESP, DONE.
  - IDLE, req=1: capture type, masked address, byte_en and wdata. Go to RD_ADDR (read) or WR (write); arvalid/awvalid assert in the next cycle.
  - RD_ADDR: arvalid=1 until arready; then RD_DATA.
  - RD_DATA: rready=1; on rvalid, latch rdata and go to DONE. rlast and rresp are ignored.
  - WR: awvalid=1 and wvalid=1, each deasserted independently after its own ready handshake.
    - When both handshakes are done (same or different cycles): WR_RESP if WAIT_RESP=1, else DONE.
  - WR_RESP: bready=1; on bvalid go to DONE. bresp is ignored.
  - DONE: one cycle, then IDLE.
- Fixed AXI fields:
  - arlen=awlen=0; arburst=awburst=2'b01.
  - arlock/awlock, arcache/awcache, arprot/awprot = 0.
  - wlast=1; wstrb=captured byte_en; wdata=captured wdata.
- Size encoding (arsize/awsize) from byte_en:
  - 4'b1111 → 2
  - 4'b0011 or 4'b1100 → 1
  - one-hot → 0
  - any other pattern → 2
- Stall: dbus_stall = req & !(state==DONE & match).
  - match = current type, masked address and byte_en equal the captured values.
  - Consequently, stall is low for exactly the DONE cycle of the matching request.
- Request withdrawn mid-transaction (flush): the AXI transaction still runs to completion. DONE is reached and the result is discarded; stall is low because req=0.
- Different request appears while busy: stall stays high. In DONE, match=0, so the bridge returns to IDLE and starts the new request on the following cycle.
- Back-to-back requests: after DONE→IDLE, a request present in IDLE starts immediately. Minimum read latency is 4 cycles with zero-wait slaves: IDLE, RD_ADDR, RD_DATA, DONE.
- Stored data is never returned for a newer request; dbus_rdata updates only on an rvalid handshake.

Test Plan:
- Read, zero-wait slave: read=1, address=32'hBFD0_0010, byte_en=4'b1111; slave returns 32'hDEAD_BEEF.
  - Required: araddr=32'h1FD0_0010, arsize=2, arlen=0.
  - dbus_stall is high for 3 cycles, then low for 1 cycle with rdata=32'hDEAD_BEEF.
- Write with AW/W skew: write=1, address=32'hA000_0004, byte_en=4'b1100, wdata=32'h1234_5678; awready arrives 1 cycle after and wready 3 cycles after their valids.
  - Required: awsize=1, wstrb=4'b1100; awvalid drops alone; wvalid drops later.
  - With WAIT_RESP=1, stall falls only after bvalid.
- Read and write together: read=1 and write=1.
  - Required: only the AW/W channels toggle; arvalid stays 0 throughout.
- Withdrawn request: drop read in the cycle after arvalid, while arready is held low for 5 cycles.
  - Required: arvalid stays high until arready, the rvalid beat is accepted, DONE passes, and stall stays 0.
- Swapped request: the read at 32'hA000_0000 is replaced by a read at 32'hA000_0008 mid-transaction.
  - Required: the first beat is discarded, a second AR issues with araddr=32'h0000_0008, and stall stays high until its DONE.
- Reset during RD_DATA: assert rst_n=0 asynchronously.
  - Required: arvalid=0, rready=0, state=IDLE, rdata=0 within the same cycle, without waiting for a clock edge.
